gpio_bank: RTL and testbench

//  Parametrised GPIO peripheral for the tinyQV peripheral bus. Replaces the fixed 8-bit gpio_out/gpio_out_sel

---
 rtl/gpio_bank_pkg.sv | 35 +++
 rtl/gpio_pin_filter.sv | 70 +++++++
 rtl/gpio_bank.sv | 139 +++++++++++++
 tb/tb_gpio_bank.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_bank_pkg.sv
// Register map, bus write-size encodings and the byte-lane mask helper shared by tinyQV peripherals.
package gpio_bank_pkg;

   localparam int unsigned GPIO_ADDR_W = 3;
   localparam int unsigned GPIO_DATA_W = 32;

   localparam logic [GPIO_ADDR_W-1:0] GPIO_REG_OUT      = 3'd0;
   localparam logic [GPIO_ADDR_W-1:0] GPIO_REG_IN       = 3'd1;
   localparam logic [GPIO_ADDR_W-1:0] GPIO_REG_OUT_SEL  = 3'd2;
   localparam logic [GPIO_ADDR_W-1:0] GPIO_REG_IRQ_EN   = 3'd3;
   localparam logic [GPIO_ADDR_W-1:0] GPIO_REG_RISE_EN  = 3'd4;
   localparam logic [GPIO_ADDR_W-1:0] GPIO_REG_FALL_EN  = 3'd5;
   localparam logic [GPIO_ADDR_W-1:0] GPIO_REG_PEND     = 3'd6;
   localparam logic [GPIO_ADDR_W-1:0] GPIO_REG_DEBOUNCE = 3'd7;

   typedef enum logic [1:0] {
      WR_BYTE = 2'b00,
      WR_HALF = 2'b01,
      WR_WORD = 2'b10,
      WR_NONE = 2'b11
   } wr_size_e;

   // Bits of the 32-bit write word that a given access size is allowed to touch.
   function automatic logic [GPIO_DATA_W-1:0] write_mask(input logic [1:0] write_n);
      logic [GPIO_DATA_W-1:0] mask;
      case (wr_size_e'(write_n))
         WR_BYTE: mask = 32'h0000_00FF;
         WR_HALF: mask = 32'h0000_FFFF;
         WR_WORD: mask = 32'hFFFF_FFFF;
         default: mask = 32'h0000_0000;
      endcase
      return mask;
   endfunction

endpackage

// File: rtl/gpio_pin_filter.sv
// Per-pin input path: synchroniser, optional debounce (GPIO_DEBOUNCE_EN), prev flop and qualified edges.
module gpio_pin_filter
   import gpio_bank_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rstn,
   input  logic pin,
   input  logic arm,
   input  logic rise_en,
   input  logic fall_en,
`ifdef GPIO_DEBOUNCE_EN
   input  logic tick,
   input  logic debounce_on,
`endif
   output logic filt_c,
   output logic rise_c,
   output logic fall_c
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   sync_bit;
   logic                   prev_q;

   assign sync_bit = sync_q[SYNC_STAGES-1];

   always_ff @(posedge clk) begin
      if (!rstn) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], pin};
         prev_q <= filt_c;
      end
   end

`ifdef GPIO_DEBOUNCE_EN
   logic       stable_q;
   logic [1:0] stab_cnt_q;

   // Accept a new level only after three consecutive ticks disagree with the held one.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         stable_q   <= 1'b0;
         stab_cnt_q <= 2'd0;
      end else if (!debounce_on) begin
         stable_q   <= sync_bit;
         stab_cnt_q <= 2'd0;
      end else if (tick) begin
         if (sync_bit == stable_q) begin
            stab_cnt_q <= 2'd0;
         end else if (stab_cnt_q == 2'd2) begin
            stable_q   <= sync_bit;
            stab_cnt_q <= 2'd0;
         end else begin
            stab_cnt_q <= stab_cnt_q + 2'd1;
         end
      end
   end

   assign filt_c = debounce_on ? stable_q : sync_bit;
`else
   assign filt_c = sync_bit;
`endif

   assign rise_c = arm & rise_en &  filt_c & ~prev_q;
   assign fall_c = arm & fall_en & ~filt_c &  prev_q;

endmodule

// File: rtl/gpio_bank.sv
// tinyQV GPIO bank: output muxing, synchronised inputs, sticky edge interrupts.
// Optional input debounce is built when GPIO_DEBOUNCE_EN is defined.
module gpio_bank
   import gpio_bank_pkg::*;
#(
   parameter int unsigned NUM_PINS    = 8,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic                   clk,
   input  logic                   rstn,
   input  logic                   sel,
   input  logic [2:0]             addr,
   input  logic [1:0]             write_n,
   input  logic [31:0]            data_in,
   output logic [31:0]            data_out,
   input  logic [NUM_PINS-1:0]    pin_in,
   input  logic [NUM_PINS-1:0]    periph_out,
   output logic [NUM_PINS-1:0]    pin_out,
   output logic                   irq
);

   localparam logic [2:0] ARM_CYC = 3'(SYNC_STAGES + 1);

   logic [NUM_PINS-1:0] out_q, out_sel_q, irq_en_q, rise_en_q, fall_en_q, pend_q;
   logic [NUM_PINS-1:0] filt, rise, fall;
   logic [NUM_PINS-1:0] wmask, wbits, pend_clr;
   logic [31:0]         wmask_full;
   logic                wr_en;
   logic [2:0]          arm_cnt_q;
   logic                armed;
   logic                unused_bits;

   assign wr_en      = sel && (wr_size_e'(write_n) != WR_NONE);
   assign wmask_full = write_mask(write_n);
   assign wmask      = NUM_PINS'(wmask_full);
   assign wbits      = NUM_PINS'(data_in) & wmask;
   assign pend_clr   = (wr_en && addr == GPIO_REG_PEND) ? wbits : '0;
   assign unused_bits = ^{data_in, wmask_full};

   // Hold off edge detection until the synchronisers have flushed after reset.
   assign armed = (arm_cnt_q == ARM_CYC);

   always_ff @(posedge clk) begin
      if (!rstn) begin
         arm_cnt_q <= 3'd0;
      end else if (!armed) begin
         arm_cnt_q <= arm_cnt_q + 3'd1;
      end
   end

`ifdef GPIO_DEBOUNCE_EN
   logic [7:0] debounce_q, tick_cnt_q;
   logic       tick, debounce_on;

   assign debounce_on = (debounce_q != 8'd0);
   assign tick        = (tick_cnt_q == debounce_q);

   // Tick divider; a DEBOUNCE write restarts the period.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         debounce_q <= 8'd0;
         tick_cnt_q <= 8'd0;
      end else if (wr_en && addr == GPIO_REG_DEBOUNCE) begin
         debounce_q <= (debounce_q & ~wmask_full[7:0]) | (data_in[7:0] & wmask_full[7:0]);
         tick_cnt_q <= 8'd0;
      end else if (tick) begin
         tick_cnt_q <= 8'd0;
      end else begin
         tick_cnt_q <= tick_cnt_q + 8'd1;
      end
   end
`endif

   for (genvar i = 0; i < NUM_PINS; i++) begin : g_pin
      gpio_pin_filter #(
         .SYNC_STAGES (SYNC_STAGES)
      ) u_filter (
         .clk         (clk),
         .rstn        (rstn),
         .pin         (pin_in[i]),
         .arm         (armed),
         .rise_en     (rise_en_q[i]),
         .fall_en     (fall_en_q[i]),
`ifdef GPIO_DEBOUNCE_EN
         .tick        (tick),
         .debounce_on (debounce_on),
`endif
         .filt_c      (filt[i]),
         .rise_c      (rise[i]),
         .fall_c      (fall[i])
      );
   end

   // Register writes; a new edge beats a same-cycle W1C on PEND.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         out_q     <= '0;
         out_sel_q <= '0;
         irq_en_q  <= '0;
         rise_en_q <= '0;
         fall_en_q <= '0;
         pend_q    <= '0;
      end else begin
         if (wr_en) begin
            case (addr)
               GPIO_REG_OUT:     out_q     <= (out_q     & ~wmask) | wbits;
               GPIO_REG_OUT_SEL: out_sel_q <= (out_sel_q & ~wmask) | wbits;
               GPIO_REG_IRQ_EN:  irq_en_q  <= (irq_en_q  & ~wmask) | wbits;
               GPIO_REG_RISE_EN: rise_en_q <= (rise_en_q & ~wmask) | wbits;
               GPIO_REG_FALL_EN: fall_en_q <= (fall_en_q & ~wmask) | wbits;
               default: ;
            endcase
         end
         pend_q <= (pend_q & ~pend_clr) | rise | fall;
      end
   end

   always_comb begin
      data_out = '0;
      case (addr)
         GPIO_REG_OUT:      data_out = 32'(out_q);
         GPIO_REG_IN:       data_out = 32'(filt);
         GPIO_REG_OUT_SEL:  data_out = 32'(out_sel_q);
         GPIO_REG_IRQ_EN:   data_out = 32'(irq_en_q);
         GPIO_REG_RISE_EN:  data_out = 32'(rise_en_q);
         GPIO_REG_FALL_EN:  data_out = 32'(fall_en_q);
         GPIO_REG_PEND:     data_out = 32'(pend_q);
`ifdef GPIO_DEBOUNCE_EN
         GPIO_REG_DEBOUNCE: data_out = 32'(debounce_q);
`else
         GPIO_REG_DEBOUNCE: data_out = '0;
`endif
      endcase
   end

   assign pin_out = (out_q & out_sel_q) | (periph_out & ~out_sel_q);
   assign irq     = |(pend_q & irq_en_q);

endmodule

// File: tb/tb_gpio_bank.sv
// Directed bench for gpio_bank (16 pins, 2 sync stages); debounce steps run when GPIO_DEBOUNCE_EN is defined.
`timescale 1ns/1ps
module tb_gpio_bank;
   import gpio_bank_pkg::*;

   localparam int unsigned NP = 16;

   logic          clk;
   logic          rstn;
   logic          sel;
   logic [2:0]    addr;
   logic [1:0]    write_n;
   logic [31:0]   data_in;
   logic [31:0]   data_out;
   logic [NP-1:0] pin_in;
   logic [NP-1:0] periph_out;
   logic [NP-1:0] pin_out;
   logic          irq;

   int errors = 0;
   int checks = 0;

   gpio_bank #(
      .NUM_PINS    (NP),
      .SYNC_STAGES (2)
   ) dut (
      .clk        (clk),
      .rstn       (rstn),
      .sel        (sel),
      .addr       (addr),
      .write_n    (write_n),
      .data_in    (data_in),
      .data_out   (data_out),
      .pin_in     (pin_in),
      .periph_out (periph_out),
      .pin_out    (pin_out),
      .irq        (irq)
   );

   initial clk = 1'b0;
   always #20 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wr(input logic [2:0] a, input logic [31:0] d, input logic [1:0] sz);
      sel     = 1'b1;
      addr    = a;
      data_in = d;
      write_n = sz;
      cyc(1);
      sel     = 1'b0;
      write_n = 2'b11;
   endtask

   task automatic check_reg(input string tag, input logic [2:0] a, input logic [31:0] exp);
      addr = a;
      #1;
      check(tag, data_out, exp);
   endtask

   initial begin
      rstn       = 1'b0;
      sel        = 1'b0;
      addr       = 3'd0;
      write_n    = 2'b11;
      data_in    = 32'h0;
      pin_in     = 16'h00FF;
      periph_out = 16'h1234;

      // 1: reset with pins held high, then arming suppresses the flush edge
      cyc(3);
      check("rst_pin_out", 32'(pin_out), 32'h0000_1234);
      check("rst_irq", 32'(irq), 32'h0);
      check_reg("rst_out", GPIO_REG_OUT, 32'h0);
      check_reg("rst_pend", GPIO_REG_PEND, 32'h0);
      check_reg("rst_in", GPIO_REG_IN, 32'h0);
      rstn = 1'b1;
      wr(GPIO_REG_RISE_EN, 32'h0000_FFFF, WR_WORD);
      wr(GPIO_REG_IRQ_EN,  32'h0000_FFFF, WR_WORD);
      cyc(1);
      check_reg("in_after_sync", GPIO_REG_IN, 32'h0000_00FF);
      for (int k = 0; k < 20; k++) begin
         check("arm_irq", 32'(irq), 32'h0);
         check_reg("arm_pend", GPIO_REG_PEND, 32'h0);
         cyc(1);
      end

      // 2: rising edge on pin 0, latency and W1C
      wr(GPIO_REG_RISE_EN, 32'h0000_0001, WR_WORD);
      wr(GPIO_REG_IRQ_EN,  32'h0000_0001, WR_WORD);
      pin_in = 16'h00FE;
      cyc(5);
      check_reg("fall_ignored", GPIO_REG_PEND, 32'h0);
      pin_in = 16'h00FF;
      cyc(2);
      check_reg("rise_early", GPIO_REG_PEND, 32'h0);
      cyc(1);
      check_reg("rise_pend", GPIO_REG_PEND, 32'h0000_0001);
      check("rise_irq", 32'(irq), 32'h1);
      wr(GPIO_REG_PEND, 32'h0000_0001, WR_WORD);
      check_reg("w1c_pend", GPIO_REG_PEND, 32'h0);
      check("w1c_irq", 32'(irq), 32'h0);

      // 3: output mux and write masking
      periph_out = 16'h003C;
      wr(GPIO_REG_OUT,     32'h0000_00A5, WR_WORD);
      wr(GPIO_REG_OUT_SEL, 32'h0000_000F, WR_WORD);
      check("pin_out_mux", 32'(pin_out), 32'h0000_0035);
      wr(GPIO_REG_OUT, 32'h0000_5AA5, WR_WORD);
      wr(GPIO_REG_OUT, 32'h0000_00FF, WR_BYTE);
      check_reg("byte_write", GPIO_REG_OUT, 32'h0000_5AFF);
      wr(GPIO_REG_OUT, 32'h1234_BEEF, WR_HALF);
      check_reg("half_write", GPIO_REG_OUT, 32'h0000_BEEF);
      wr(GPIO_REG_OUT, 32'h0000_1111, WR_NONE);
      check_reg("no_write", GPIO_REG_OUT, 32'h0000_BEEF);
      write_n = WR_WORD;
      data_in = 32'h0000_2222;
      addr    = GPIO_REG_OUT;
      cyc(1);
      write_n = 2'b11;
      check_reg("unselected", GPIO_REG_OUT, 32'h0000_BEEF);
      check("pin_out_beef", 32'(pin_out), 32'h0000_003F);

      // 4: falling edge on pin 3 collides with W1C of bit 3
      wr(GPIO_REG_RISE_EN, 32'h0, WR_WORD);
      wr(GPIO_REG_FALL_EN, 32'h0000_0008, WR_WORD);
      pin_in = 16'h00F7;
      cyc(4);
      check_reg("fall_pend", GPIO_REG_PEND, 32'h0000_0008);
      pin_in = 16'h00FF;
      cyc(4);
      check_reg("sticky_pend", GPIO_REG_PEND, 32'h0000_0008);
      pin_in = 16'h00F7;
      cyc(2);
      wr(GPIO_REG_PEND, 32'h0000_0008, WR_WORD);
      check_reg("set_wins", GPIO_REG_PEND, 32'h0000_0008);
      wr(GPIO_REG_PEND, 32'h0000_0008, WR_WORD);
      check_reg("clr_after", GPIO_REG_PEND, 32'h0);

      // both edges enabled: each transition pends
      wr(GPIO_REG_RISE_EN, 32'h0000_0008, WR_WORD);
      pin_in = 16'h00FF;
      cyc(4);
      check_reg("both_rise", GPIO_REG_PEND, 32'h0000_0008);
      wr(GPIO_REG_PEND, 32'h0000_0008, WR_WORD);
      pin_in = 16'h00F7;
      cyc(4);
      check_reg("both_fall", GPIO_REG_PEND, 32'h0000_0008);
      wr(GPIO_REG_PEND, 32'h0000_0008, WR_WORD);
      check_reg("both_clr", GPIO_REG_PEND, 32'h0);

      // 5: debounce
`ifdef GPIO_DEBOUNCE_EN
      wr(GPIO_REG_FALL_EN,  32'h0, WR_WORD);
      wr(GPIO_REG_RISE_EN,  32'h0000_0002, WR_WORD);
      wr(GPIO_REG_DEBOUNCE, 32'h0000_0003, WR_WORD);
      check_reg("deb_read", GPIO_REG_DEBOUNCE, 32'h0000_0003);
      pin_in = 16'h00F5;
      cyc(20);
      wr(GPIO_REG_PEND, 32'h0000_FFFF, WR_WORD);
      pin_in = 16'h00F7;
      cyc(5);
      pin_in = 16'h00F5;
      cyc(20);
      check_reg("deb_pulse", GPIO_REG_PEND, 32'h0);
      pin_in = 16'h00F7;
      cyc(20);
      check_reg("deb_held", GPIO_REG_PEND, 32'h0000_0002);
`else
      wr(GPIO_REG_DEBOUNCE, 32'h0000_0003, WR_WORD);
      check_reg("deb_absent", GPIO_REG_DEBOUNCE, 32'h0);
`endif
      wr(GPIO_REG_DEBOUNCE, 32'h0, WR_WORD);

      // 6: reset mid-edge with every pin pending
      wr(GPIO_REG_RISE_EN, 32'h0, WR_WORD);
      wr(GPIO_REG_FALL_EN, 32'h0, WR_WORD);
      pin_in = 16'h0000;
      cyc(5);
      wr(GPIO_REG_RISE_EN, 32'h0000_FFFF, WR_WORD);
      wr(GPIO_REG_FALL_EN, 32'h0000_FFFF, WR_WORD);
      wr(GPIO_REG_PEND,    32'h0000_FFFF, WR_WORD);
      check_reg("pre_clear", GPIO_REG_PEND, 32'h0);
      pin_in = 16'hFFFF;
      cyc(4);
      check_reg("all_pend", GPIO_REG_PEND, 32'h0000_FFFF);
      check("all_irq", 32'(irq), 32'h1);
      pin_in = 16'h5555;
      cyc(1);
      rstn = 1'b0;
      cyc(1);
      rstn = 1'b1;
      check_reg("mid_out",     GPIO_REG_OUT,      32'h0);
      check_reg("mid_in",      GPIO_REG_IN,       32'h0);
      check_reg("mid_outsel",  GPIO_REG_OUT_SEL,  32'h0);
      check_reg("mid_irqen",   GPIO_REG_IRQ_EN,   32'h0);
      check_reg("mid_riseen",  GPIO_REG_RISE_EN,  32'h0);
      check_reg("mid_fallen",  GPIO_REG_FALL_EN,  32'h0);
      check_reg("mid_pend",    GPIO_REG_PEND,     32'h0);
      check_reg("mid_deb",     GPIO_REG_DEBOUNCE, 32'h0);
      check("mid_pin_out", 32'(pin_out), 32'h0000_003C);
      check("mid_irq", 32'(irq), 32'h0);
      wr(GPIO_REG_RISE_EN, 32'h0000_FFFF, WR_WORD);
      wr(GPIO_REG_FALL_EN, 32'h0000_FFFF, WR_WORD);
      cyc(10);
      check_reg("post_rst_pend", GPIO_REG_PEND, 32'h0);
      check_reg("post_rst_in", GPIO_REG_IN, 32'h0000_5555);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
